// File: rtl/mem_arbiter.sv
// Two-requester arbiter for data-memory port 1: instruction fetch (A) and
// load/store (B), one issue per cycle, B-priority with an A starvation override.
module mem_arbiter #(
    parameter int MEM_WORDS    = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req_i,
    input  logic [15:0] a_addr_i,
    output logic        a_ack_o,
    output logic        a_rvalid_o,
    output logic [15:0] a_rdata_o,
    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic        b_byte_enable_i,
    input  logic        b_byte_select_i,
    input  logic [15:0] b_addr_i,
    input  logic [15:0] b_wdata_i,
    output logic        b_ack_o,
    output logic        b_rvalid_o,
    output logic [15:0] b_rdata_o,
    output logic        b_err_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic        mem_byte_enable_o,
    output logic        mem_byte_select_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_wait_i
);
    localparam logic [15:0] WORDS = 16'(MEM_WORDS);
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {G_NONE, G_A, G_B} grant_t;

    grant_t      grant;
    logic [3:0]  starve_q, starve_d;
    logic        pend_q, pend_d;
    logic        pend_b_q, pend_b_d;
    logic        pend_oor_q, pend_oor_d;
    logic        b_err_q, b_err_d;
    logic        stall, a_in, b_in, deliver;

    // A returning read that the memory is still stalling blocks any new issue.
    assign stall = pend_q && mem_wait_i;
    assign a_in  = a_addr_i < WORDS;
    assign b_in  = b_addr_i < WORDS;

    always_comb begin
        grant = G_NONE;
        if (!rst && !stall) begin
            if (starve_q == LIMIT && a_req_i) grant = G_A;
            else if (b_req_i)                 grant = G_B;
            else if (a_req_i)                 grant = G_A;
        end
    end

    assign a_ack_o = (grant == G_A);
    assign b_ack_o = (grant == G_B);

    always_comb begin
        mem_en_o          = 1'b0;
        mem_we_o          = 1'b0;
        mem_byte_enable_o = 1'b0;
        mem_byte_select_o = 1'b0;
        mem_addr_o        = '0;
        mem_wdata_o       = '0;
        case (grant)
            G_A: begin
                mem_en_o   = a_in;
                mem_addr_o = a_addr_i;
            end
            G_B: begin
                // Out-of-range accesses are acked but never reach the memory.
                mem_en_o          = b_in;
                mem_we_o          = b_we_i && b_in;
                mem_byte_enable_o = b_byte_enable_i;
                mem_byte_select_o = b_byte_select_i;
                mem_addr_o        = b_addr_i;
                mem_wdata_o       = b_wdata_i;
            end
            default: ;
        endcase
    end

    assign deliver    = pend_q && !mem_wait_i && !rst;
    assign a_rvalid_o = deliver && !pend_b_q;
    assign b_rvalid_o = deliver && pend_b_q;
    assign a_rdata_o  = (a_rvalid_o && !pend_oor_q) ? mem_rdata_i : 16'h0000;
    assign b_rdata_o  = (b_rvalid_o && !pend_oor_q) ? mem_rdata_i : 16'h0000;
    assign b_err_o    = b_err_q;

    always_comb begin
        starve_d   = starve_q;
        pend_d     = pend_q;
        pend_b_d   = pend_b_q;
        pend_oor_d = pend_oor_q;
        b_err_d    = (grant == G_B) && !b_in;
        if (!stall) begin
            pend_d     = (grant == G_A) || (grant == G_B && !b_we_i);
            pend_b_d   = (grant == G_B);
            pend_oor_d = (grant == G_A) ? !a_in : !b_in;
            if (grant == G_B && a_req_i)
                starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
            else
                starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= '0;
            pend_q     <= 1'b0;
            pend_b_q   <= 1'b0;
            pend_oor_q <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            pend_q     <= pend_d;
            pend_b_q   <= pend_b_d;
            pend_oor_q <= pend_oor_d;
            b_err_q    <= b_err_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a cycle-level
// reference of the grant/return rules and a shadow copy of memory contents.
module tb_mem_arbiter;
    localparam int MW = 64;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst;
    logic a_req, a_ack, a_rvalid;
    logic [15:0] a_addr, a_rdata;
    logic b_req, b_we, b_be, b_bs, b_ack, b_rvalid, b_err;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic mem_en, mem_we, mem_be, mem_bs, mem_wait;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic preload;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_WORDS(MW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .a_req_i(a_req), .a_addr_i(a_addr), .a_ack_o(a_ack),
        .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_byte_enable_i(b_be),
        .b_byte_select_i(b_bs), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_byte_enable_o(mem_be),
        .mem_byte_select_o(mem_bs), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_wait_i(mem_wait)
    );

    function automatic logic [15:0] init_val(int i);
        return (i == 5) ? 16'hBEEF : 16'((i * 16'h1357) ^ 16'h5A5A);
    endfunction

    // Memory with a registered-address read; data_out holds between reads.
    logic [15:0] phys [0:MW-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MW; i++) phys[i] <= init_val(i);
            mem_rdata <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) begin
                if (!mem_be)     phys[mem_addr[5:0]]       <= mem_wdata;
                else if (mem_bs) phys[mem_addr[5:0]][15:8] <= mem_wdata[7:0];
                else             phys[mem_addr[5:0]][7:0]  <= mem_wdata[7:0];
            end else begin
                if (!mem_be)     mem_rdata <= phys[mem_addr[5:0]];
                else if (mem_bs) mem_rdata <= {8'h00, phys[mem_addr[5:0]][15:8]};
                else             mem_rdata <= {8'h00, phys[mem_addr[5:0]][7:0]};
            end
        end
    end

    logic [15:0] ref_mem [0:MW-1];
    int          m_starve = 0;
    bit          m_pend = 0, m_pend_b = 0, m_berr = 0;
    logic [15:0] m_pdata = 16'h0000;
    int          n_pass = 0, n_tot = 0, n_fail = 0;
    bit          last_a_ack = 0, last_b_ack = 0;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp_v);
        n_tot++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One cycle: predict, compare before the edge, then advance the model.
    task automatic tick();
        int          g;
        bit          stall, oor, deliver;
        logic [15:0] w;
        #1;
        stall = m_pend && mem_wait;
        g = 0;
        if (!rst && !stall) begin
            if (m_starve >= SL && a_req) g = 1;
            else if (b_req)              g = 2;
            else if (a_req)              g = 1;
        end
        oor = (g == 1) ? (a_addr >= MW) : (b_addr >= MW);
        deliver = !rst && m_pend && !mem_wait;
        chk("a_ack",  a_ack,  g == 1);
        chk("b_ack",  b_ack,  g == 2);
        chk("mem_en", mem_en, g != 0 && !oor);
        chk("mem_we", mem_we, g == 2 && b_we && !oor);
        if (g != 0 && !oor) chk("mem_addr", mem_addr, (g == 1) ? a_addr : b_addr);
        chk("a_rvalid", a_rvalid, deliver && !m_pend_b);
        chk("a_rdata",  a_rdata,  (deliver && !m_pend_b) ? m_pdata : 16'h0000);
        chk("b_rvalid", b_rvalid, deliver && m_pend_b);
        chk("b_rdata",  b_rdata,  (deliver && m_pend_b) ? m_pdata : 16'h0000);
        chk("b_err",    b_err,    m_berr);
        last_a_ack = a_ack;
        last_b_ack = b_ack;
        @(posedge clk);
        if (rst) begin
            m_starve = 0; m_pend = 0; m_pend_b = 0; m_berr = 0;
        end else begin
            m_berr = (g == 2) && oor;
            if (!stall) begin
                m_starve = (g == 2 && a_req) ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
                m_pend   = (g == 1) || (g == 2 && !b_we);
                m_pend_b = (g == 2);
                if (m_pend) begin
                    if (oor)         m_pdata = 16'h0000;
                    else if (g == 1) m_pdata = ref_mem[a_addr[5:0]];
                    else begin
                        w = ref_mem[b_addr[5:0]];
                        m_pdata = !b_be ? w : (b_bs ? {8'h00, w[15:8]} : {8'h00, w[7:0]});
                    end
                end
                if (g == 2 && b_we && !oor) begin
                    if (!b_be)     ref_mem[b_addr[5:0]]       = b_wdata;
                    else if (b_bs) ref_mem[b_addr[5:0]][15:8] = b_wdata[7:0];
                    else           ref_mem[b_addr[5:0]][7:0]  = b_wdata[7:0];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_a(input logic req, input logic [15:0] addr);
        a_req = req; a_addr = addr;
    endtask

    task automatic set_b(input logic req, input logic we, input logic be, input logic bs,
                         input logic [15:0] addr, input logic [15:0] wd);
        b_req = req; b_we = we; b_be = be; b_bs = bs; b_addr = addr; b_wdata = wd;
    endtask

    function automatic logic [15:0] rand_addr();
        return ($urandom_range(0, 9) == 0) ? 16'($urandom_range(64, 200))
                                           : 16'($urandom_range(0, 63));
    endfunction

    initial begin
        rst = 1'b1; preload = 1'b1; mem_wait = 1'b0;
        set_a(0, 0); set_b(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MW; i++) ref_mem[i] = init_val(i);
        @(negedge clk); @(negedge clk);
        preload = 1'b0;

        // Reset with both requesting, then B wins first.
        set_a(1, 7); set_b(1, 0, 0, 0, 9, 0);
        tick(); tick();
        rst = 1'b0; tick();
        b_req = 0; tick();
        a_req = 0; tick();

        // Single A read of word 5.
        set_a(1, 5); tick();
        a_req = 0; tick(); tick();

        // High-byte write then word read of word 3.
        set_b(1, 1, 1, 1, 3, 16'h00A5); tick();
        set_b(1, 0, 0, 0, 3, 0); tick();
        b_req = 0; tick(); tick();

        // Continuous contention: B,B,B,B,A pattern.
        set_a(1, 10); set_b(1, 0, 0, 0, 20, 0);
        repeat (12) tick();
        a_req = 0; b_req = 0; tick(); tick();

        // Out-of-range read and write.
        set_b(1, 0, 0, 0, 64, 0); tick();
        set_b(1, 1, 0, 0, 100, 16'h1234); tick();
        b_req = 0; tick(); tick();

        // Stalled return, delivered on the first cycle without wait.
        set_a(1, 5); tick();
        mem_wait = 1; set_b(1, 0, 0, 0, 2, 0); tick(); tick();
        mem_wait = 0; tick();
        a_req = 0; b_req = 0; tick(); tick();

        // Reset while a read is in flight.
        set_a(1, 6); tick();
        a_req = 0; rst = 1; tick();
        rst = 0; tick(); tick();

        // Randomized traffic; requesters hold until acknowledged.
        repeat (400) begin
            if (!a_req || last_a_ack)
                set_a(1'($urandom_range(0, 2) != 0), rand_addr());
            if (!b_req || last_b_ack)
                set_b(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
                      1'($urandom), rand_addr(), 16'($urandom));
            mem_wait = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing port 1 of the on-chip data memory.
- Requester A is instruction fetch: word reads only. Requester B is data load/store: word or byte, read or write.
- Pipelined issue of one access per cycle; read data returns one cycle after issue, matching the memory's registered-address read.
- B has priority by default. A starvation counter guarantees A forward progress. Out-of-range addresses are filtered so the memory never sees them.

Parameters:
- MEM_WORDS, 64, number of 16-bit words in the memory; word addresses >= MEM_WORDS are out of range.
- STARVE_LIMIT, 4, consecutive cycles A may be denied before A is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  A requests a word read.
- a_addr  in  16  A word address.
- a_ack  out  1  A request accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered).
- a_rdata  out  16  A read data; 0 when a_rvalid=0.
- b_req  in  1  B request.
- b_we  in  1  B write enable.
- b_byte_enable  in  1  B byte access.
- b_byte_select  in  1  B byte lane: 1 = high byte, 0 = low byte.
- b_addr  in  16  B word address.
- b_wdata  in  16  B write data (byte writes use [7:0]).
- b_ack  out  1  B request accepted this cycle (combinational).
- b_rvalid  out  1  B read data valid (registered).
- b_rdata  out  16  B read data; 0 when b_rvalid=0.
- b_err  out  1  one-cycle pulse, B out-of-range access accepted (registered).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_byte_enable  out  1  to memory.
- mem_byte_select  out  1  to memory.
- mem_addr  out  16  to memory.
- mem_wdata  out  16  to memory.
- mem_rdata  in  16  memory data_out.
- mem_wait  in  1  memory stall.

Behaviour:
- Reset: all registered outputs 0. Starvation counter 0. Pending-read state cleared. During rst: a_ack=b_ack=0, mem_en=0, mem_we=0.
- Grant is computed combinationally in cycle T:
  - Stall: if a read is pending and mem_wait=1, there is no grant.
  - Starved: else if starve_cnt==STARVE_LIMIT and a_req=1, A wins.
  - Default: else B wins if b_req=1; else A wins if a_req=1.
- Exactly one of a_ack/b_ack is high in a grant cycle; neither when nothing is granted. A requester holds req and its inputs stable until it sees ack.
- Issue: the granted requester's fields drive mem_* in cycle T.
  - mem_en=1 only if the address is < MEM_WORDS.
  - For A: mem_we=0, mem_byte_enable=0, mem_byte_select=0.
  - When nothing is granted: mem_en=0, mem_we=0, remaining mem_* outputs 0.
- Read return: a read granted in T sets pending{owner, oor} at the T edge.
  - In T+1, if mem_wait=0: owner's rvalid=1.
  - owner's rdata = mem_rdata, or 16'h0000 if oor.
  - The memory performs byte extraction; the arbiter passes data through.
  - If mem_wait=1 in T+1: rvalid stays 0 and pending holds. Data is delivered in the first cycle with mem_wait=0.
- A new grant may coincide with a returning read, giving back-to-back throughput of 1 access per cycle when mem_wait=0.
- Writes produce no rvalid. An out-of-range write is acked and dropped (mem_en=0).
- b_err pulses in T+1 for any out-of-range B access, read or write. Out-of-range A reads return 0 silently.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when a_req=1 and B was granted.
  - Clears when A is granted or a_req=0.
  - Holds during stall cycles.
- Reset mid-operation: a pending read is discarded; no rvalid is asserted after rst deasserts until a new read is granted.

Test Plan:
- Reset values: assert rst 2 cycles with a_req=b_req=1 -> a_ack=b_ack=0, mem_en=0, all rvalid/rdata/b_err 0; after release B granted first.
- Single read: memory word 5 = 16'hBEEF; a_req, a_addr=5 -> a_ack in T, a_rvalid=1 with a_rdata=16'hBEEF in T+1; a_rvalid=0 in T+2.
- Byte write/read: B writes byte_enable=1, byte_select=1, addr=3, wdata=16'h00A5, then reads word 3 -> b_rdata[15:8]=8'hA5 with low byte unchanged, one cycle after the read ack.
- Starvation: hold a_req and b_req high continuously with STARVE_LIMIT=4 -> grant pattern B,B,B,B,A repeating; a_rvalid every 5th cycle + 1.
- Out of range: B read at addr=64 -> b_ack, mem_en=0, T+1 b_rvalid=1, b_rdata=0, b_err=1; B write at addr=100 -> memory unchanged, b_err=1.
- Stall: A read granted, force mem_wait=1 for 2 cycles -> no acks and a_rvalid=0 during stall; a_rvalid with correct data in the first cycle mem_wait=0. Separately, assert rst in T+1 of a read -> no a_rvalid afterwards.
